// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS event path toward the RAVENS-side consumer.
package dvs_ravens_pkg;

  localparam int EVENT_BITS    = 16;
  localparam int FIFO_DEPTH    = 16;
  localparam int NUM_EVENT_SRC = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/event_sync_fifo.sv
// Single-clock circular event FIFO with a first-word-fall-through valid/ready read port.
module event_sync_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DATA_W = EVENT_BITS,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  // Full guard is belt-and-braces: the arbiter never grants into a full FIFO.
  assign push     = wr_en && !full;
  assign pop      = rd_valid && rd_ready;

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/dvs_event_fifo_arbiter.sv
// Round-robin arbiter over the producers' req/grant/wr_en bus, feeding one event FIFO.
module dvs_event_fifo_arbiter
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_SRC = NUM_EVENT_SRC,
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int EVENT_W = EVENT_BITS,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] fifo_req,
  input  logic [NUM_SRC-1:0] fifo_wr_en,
  input  logic [EVENT_W-1:0] fifo_event [NUM_SRC],
  output logic [NUM_SRC-1:0] fifo_grant,
  output logic               out_valid,
  output logic [EVENT_W-1:0] out_event,
  input  logic               out_ready,
  output logic [CW-1:0]      fifo_count,
  output logic               proto_err
);

  arb_state_t        state, state_nxt;
  logic [SW-1:0]     sel, sel_nxt;
  logic [SW-1:0]     rr_ptr, rr_nxt;
  logic [SW-1:0]     pick;
  logic              pick_found;
  logic              wrote, wrote_nxt;
  logic [NUM_SRC-1:0] grant_nxt;
  logic              accept;
  logic              err_now;
  logic              full;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && fifo_req[(int'(rr_ptr) + i) % NUM_SRC]) begin
        pick_found = 1'b1;
        pick       = SW'((int'(rr_ptr) + i) % NUM_SRC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      sel        <= '0;
      rr_ptr     <= '0;
      wrote      <= 1'b0;
      fifo_grant <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      rr_ptr     <= rr_nxt;
      wrote      <= wrote_nxt;
      fifo_grant <= grant_nxt;
      if (err_now) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_found && !full) begin
          state_nxt = ARB_GRANT;
          sel_nxt   = pick;
        end
      end
      ARB_GRANT: begin
        if (!fifo_req[sel]) begin
          state_nxt = ARB_IDLE;
          rr_nxt    = (sel == SW'(NUM_SRC - 1)) ? '0 : sel + SW'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // In GRANT the registered grant is one-hot on sel, so wr_en[sel] implies a granted write.
  always_comb begin
    grant_nxt = '0;
    if (state_nxt == ARB_GRANT) grant_nxt[sel_nxt] = 1'b1;
    accept    = (state == ARB_GRANT) && fifo_wr_en[sel] && !wrote;
    err_now   = (|(fifo_wr_en & ~fifo_grant)) ||
                ((state == ARB_GRANT) && fifo_wr_en[sel] && wrote);
    wrote_nxt = (state == ARB_GRANT) && (state_nxt == ARB_GRANT) && (wrote || accept);
  end

  event_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (EVENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_data  (fifo_event[sel]),
    .full     (full),
    .rd_valid (out_valid),
    .rd_data  (out_event),
    .rd_ready (out_ready),
    .count    (fifo_count)
  );

endmodule
